multi_blink: RTL

Parametrised multi-channel LED driver that replaces the single fixed-tap blinker. Each of CHANNELS outputs has its own runtime-programmable period counter and mode: off, on, square-wave blink or 256-step PWM. A one-cycle tick per channel is exported for scope/test pins. A global sync input phase-aligns all channels. The block sits directly behind the board clock and drives LED and TEST_IO pins.

---
 rtl/multi_blink_if.sv | 22 ++
 rtl/multi_blink.sv | 127 ++++++++++++
 2 files changed

// File: rtl/multi_blink_if.sv
// Configuration write channel of multi_blink: valid/ready handshake plus the
// per-channel mode, period and duty fields.
interface multi_blink_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [3:0]           cfg_ch;
    logic [1:0]           cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [7:0]           cfg_duty;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/multi_blink.sv
// Multi-channel LED driver: per-channel programmable period counter with
// OFF / ON / square-wave BLINK / 256-step PWM modes and a global phase sync.
module multi_blink #(
    parameter int                   CHANNELS       = 4,
    parameter int                   CNT_WIDTH      = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = CNT_WIDTH'(24'hFFFFFF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    multi_blink_if.slave        cfg,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Per-channel configuration and running state.
    mode_e                mode_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] period_q [CHANNELS];
    logic [7:0]           duty_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [7:0]           phase_q  [CHANNELS];

    mode_e                mode_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] period_d [CHANNELS];
    logic [7:0]           duty_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
    logic [7:0]           phase_d  [CHANNELS];
    logic [CHANNELS-1:0]  led_d;
    logic [CHANNELS-1:0]  tick_d;

    logic                 ready_q;
    logic                 accept;
    logic [CHANNELS-1:0]  wr_hit;
    logic [CHANNELS-1:0]  wrap;
    mode_e                new_mode;

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;
    assign new_mode      = mode_e'(cfg.cfg_mode);

    // Out-of-range channel indices match no bit here, so such writes are
    // accepted by the handshake but touch nothing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = accept && (cfg.cfg_ch == 4'(i));
            wrap[i]   = (cnt_q[i] == period_q[i]);
        end
    end

    // Precedence per channel: free-running update, then sync, then a write
    // to this channel (a write on a sync edge still restarts from zero).
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            duty_d[i]   = duty_q[i];
            cnt_d[i]    = wrap[i] ? '0 : cnt_q[i] + CNT_WIDTH'(1);
            phase_d[i]  = wrap[i] ? phase_q[i] + 8'd1 : phase_q[i];
            tick_d[i]   = wrap[i];
            led_d[i]    = 1'b0;

            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = led[i] ^ wrap[i];
                MODE_PWM:   led_d[i] = (phase_q[i] < duty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase

            if (sync) begin
                cnt_d[i]   = '0;
                phase_d[i] = '0;
                tick_d[i]  = 1'b0;
                if (mode_q[i] == MODE_BLINK) begin
                    led_d[i] = 1'b0;
                end
            end

            if (wr_hit[i]) begin
                mode_d[i]   = new_mode;
                period_d[i] = cfg.cfg_period;
                duty_d[i]   = cfg.cfg_duty;
                cnt_d[i]    = '0;
                phase_d[i]  = '0;
                tick_d[i]   = 1'b0;
                led_d[i]    = (new_mode == MODE_ON);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            led     <= '0;
            tick    <= '0;
            // NOTE: these arrays are flops, not RAM, and every channel must come out of reset with a known config.
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= DEFAULT_PERIOD;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
                phase_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ready_q <= 1'b1;
            led     <= led_d;
            tick    <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                duty_q[i]   <= duty_d[i];
                cnt_q[i]    <= cnt_d[i];
                phase_q[i]  <= phase_d[i];
            end
        end
    end

endmodule
